// File: rtl/sumador.sv
// PC + INC incrementer with carry flag, registered sum and optional
// alignment check (enabled by defining SUMADOR_ALIGN_CHK_EN).
module sumador #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] INC   = WIDTH'(4)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] Suma,
    output logic             Acarreo,
    output logic [WIDTH-1:0] Suma_reg,
    output logic             Desalineado,
    output logic             Error_alin
);

    logic [WIDTH:0]   sum_w;
    logic [WIDTH-1:0] suma_q;
    logic [WIDTH-1:0] suma_d;

    // Widen by one bit so the wrap past the top of the address space
    // shows up as the carry.
    assign sum_w   = {1'b0, PC} + {1'b0, INC};
    assign Suma    = sum_w[WIDTH-1:0];
    assign Acarreo = sum_w[WIDTH];

    assign suma_d   = Suma;
    assign Suma_reg = suma_q;

    // Observation copy of the sequential next-PC candidate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            suma_q <= '0;
        end else begin
            suma_q <= suma_d;
        end
    end

`ifdef SUMADOR_ALIGN_CHK_EN
    logic err_q;
    logic err_d;

    assign Desalineado = |PC[1:0];
    assign err_d       = err_q | Desalineado;
    assign Error_alin  = err_q;

    // Sticky flag: once a misaligned fetch is sampled it stays set
    // until reset, regardless of later aligned PCs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign Desalineado = 1'b0;
    assign Error_alin  = 1'b0;
`endif

endmodule

// File: tb/tb_sumador.sv
// Self-checking bench for sumador: directed steps followed by random
// PCs compared against an arithmetic reference model.
module tb_sumador;

`ifdef SUMADOR_ALIGN_CHK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk    = 1'b0;
    logic        clk_en = 1'b0;
    logic        reset  = 1'b0;
    logic [31:0] PC     = 32'h0;
    logic [31:0] Suma;
    logic        Acarreo;
    logic [31:0] Suma_reg;
    logic        Desalineado;
    logic        Error_alin;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_reg = 32'h0;
    logic        exp_err = 1'b0;

    sumador dut (
        .clk         (clk),
        .reset       (reset),
        .PC          (PC),
        .Suma        (Suma),
        .Acarreo     (Acarreo),
        .Suma_reg    (Suma_reg),
        .Desalineado (Desalineado),
        .Error_alin  (Error_alin)
    );

    always #5 clk = clk_en ? ~clk : 1'b0;

    function automatic logic [32:0] ref_add(input logic [31:0] p);
        longint unsigned s;
        s = 64'(p) + 64'd4;
        return s[32:0];
    endfunction

    function automatic logic ref_mis(input logic [31:0] p);
        return ALIGN_EN && ((p % 4) != 0);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_comb(input string tag);
        logic [32:0] r;
        r = ref_add(PC);
        check({tag, "_suma"}, Suma, r[31:0]);
        check({tag, "_carry"}, 32'(Acarreo), 32'(r[32]));
        check({tag, "_desal"}, 32'(Desalineado), 32'(ref_mis(PC)));
    endtask

    task automatic check_state(input string tag);
        check({tag, "_reg"}, Suma_reg, exp_reg);
        check({tag, "_err"}, 32'(Error_alin), 32'(exp_err));
    endtask

    task automatic tick();
        logic [32:0] r;
        r = ref_add(PC);
        @(posedge clk);
        exp_reg = r[31:0];
        exp_err = exp_err | ref_mis(PC);
        #1;
    endtask

    task automatic pulse_reset();
        #1 reset = 1'b1;
        #1;
        exp_reg = 32'h0;
        exp_err = 1'b0;
        check_state("rst_async");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        #1;
        check_state("reset");

        PC = 32'h0000_0000; #10;
        check_comb("pc0");
        check("pc0_val", Suma, 32'h0000_0004);
        PC = 32'h0000_0004; #10;
        check_comb("pc4");
        PC = 32'h0000_0008; #10;
        check_comb("pc8");
        check("pc8_val", Suma, 32'h0000_000C);

        PC = 32'hFFFF_FFFC; #10;
        check_comb("wrap");
        check("wrap_c", 32'(Acarreo), 32'h1);
        PC = 32'hFFFF_FFF8; #10;
        check_comb("nowrap");
        check_state("held_rst");

        clk_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        PC = 32'h0000_0100;
        tick();
        check_state("load");
        check("load_val", Suma_reg, 32'h0000_0104);

        #2 reset = 1'b1;
        #1;
        exp_reg = 32'h0;
        exp_err = 1'b0;
        check_state("mid_rst");
        check("mid_rst_suma", Suma, 32'h0000_0104);
        @(negedge clk);
        reset = 1'b0;

        PC = 32'h0000_0002; #1;
        check_comb("mis");
        check_state("mis_pre");
        tick();
        check_state("mis_post");
        check("mis_suma", Suma, 32'h0000_0006);
        PC = 32'h0000_0010; #1;
        check_comb("realign");
        tick();
        check_state("sticky");
        check("sticky_err", 32'(Error_alin), 32'(ALIGN_EN));
        pulse_reset();

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: PC = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
                1: PC = $urandom & 32'hFFFF_FFFC;
                default: PC = $urandom;
            endcase
            #1;
            check_comb("rnd");
            tick();
            check_state("rnd");
            if ($urandom_range(0, 7) == 0) begin
                pulse_reset();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
